// File: rtl/branch_flush_ctrl_pkg.sv
// branch_flush_ctrl_pkg: shared FSM state, BHT counter encodings and PC step.
package branch_flush_ctrl_pkg;
    typedef enum logic {IDLE = 1'b0, RECOVER = 1'b1} state_t;
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;
    localparam logic [31:0] PC_STEP = 32'd4;
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        return taken ? ((ctr == ST) ? ST : ctr + 2'd1) : ((ctr == SNT) ? SNT : ctr - 2'd1);
    endfunction
endpackage

// File: rtl/bht_2bit.sv
// bht_2bit: table of 2-bit saturating counters, async read, one sync update port.
module bht_2bit
    import branch_flush_ctrl_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(ENTRIES)-1:0] i_rd_idx,
    output logic [1:0]                 o_rd_ctr,
    input  logic                       i_we,
    input  logic [$clog2(ENTRIES)-1:0] i_wr_idx,
    input  logic                       i_wr_taken
);
    logic [1:0] r_tbl [ENTRIES];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) r_tbl[i] <= WNT;
        end else if (i_we) begin
            r_tbl[i_wr_idx] <= sat_update(r_tbl[i_wr_idx], i_wr_taken);
        end
    end
    // Read is pre-update, so a same-cycle write to the same entry is not visible yet.
    assign o_rd_ctr = r_tbl[i_rd_idx];
endmodule

// File: rtl/branch_flush_ctrl.sv
// branch_flush_ctrl: BHT-predicted ID redirect plus EX mispredict redirect/flush recovery.
module branch_flush_ctrl
    import branch_flush_ctrl_pkg::*;
#(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_is_branch,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_imm,
    output logic        pred_taken,
    output logic        id_redirect_valid,
    output logic [31:0] id_redirect_pc,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_pred_taken,
    input  logic        ex_stall,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic        cmp_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_if,
    output logic        flush_id,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);
    localparam int IW = $clog2(BHT_ENTRIES);
    state_t      r_state, w_state_nxt;
    logic [2:0]  r_flush_cnt;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc, r_branch_cnt, r_mispred_cnt;
    logic [1:0]  w_rd_ctr;
    logic        w_resolve, w_mispredict;
    bht_2bit #(.ENTRIES(BHT_ENTRIES)) u_bht (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (id_pc[IW+1:2]),
        .o_rd_ctr   (w_rd_ctr),
        .i_we       (w_resolve),
        .i_wr_idx   (ex_pc[IW+1:2]),
        .i_wr_taken (cmp_taken)
    );
    assign w_resolve         = ex_valid & ex_is_branch & ~ex_stall & (r_state == IDLE);
    assign w_mispredict      = w_resolve & (cmp_taken != ex_pred_taken);
    assign pred_taken        = id_is_branch & w_rd_ctr[1];
    assign id_redirect_valid = id_valid & id_is_branch & pred_taken & (r_state == IDLE) & ~w_mispredict;
    assign id_redirect_pc    = id_pc + id_imm;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_flush_cnt      <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_branch_cnt     <= '0;
            r_mispred_cnt    <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_flush_cnt      <= w_mispredict ? 3'(FLUSH_CYCLES) : (r_flush_cnt != 3'd0 ? r_flush_cnt - 3'd1 : 3'd0);
            r_redirect_valid <= w_mispredict;
            if (w_mispredict) r_redirect_pc <= cmp_taken ? ex_pc + ex_imm : ex_pc + PC_STEP;
            r_branch_cnt     <= r_branch_cnt + 32'(w_resolve);
            r_mispred_cnt    <= r_mispred_cnt + 32'(w_mispredict);
        end
    end
    // Down-counter holds FLUSH_CYCLES on entry; leaving when it reaches 1 gives exactly that many flush cycles.
    always_comb begin
        w_state_nxt = (r_state == IDLE) ? (w_mispredict ? RECOVER : IDLE)
                                        : ((r_flush_cnt == 3'd1) ? IDLE : RECOVER);
    end
    always_comb begin
        flush_if = (r_state == RECOVER);
        flush_id = (r_state == RECOVER);
    end
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign branch_cnt     = r_branch_cnt;
    assign mispred_cnt    = r_mispred_cnt;
endmodule

// File: tb/tb_branch_flush_ctrl.sv
// tb_branch_flush_ctrl: directed vectors with hand-computed expectations for branch_flush_ctrl.
module tb_branch_flush_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_is_branch, pred_taken, id_redirect_valid;
    logic [31:0] id_pc, id_imm, id_redirect_pc;
    logic        ex_valid, ex_is_branch, ex_pred_taken, ex_stall, cmp_taken;
    logic [31:0] ex_pc, ex_imm;
    logic        redirect_valid, flush_if, flush_id;
    logic [31:0] redirect_pc, branch_cnt, mispred_cnt;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    branch_flush_ctrl #(.BHT_ENTRIES(16), .FLUSH_CYCLES(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_valid          (id_valid),
        .id_is_branch      (id_is_branch),
        .id_pc             (id_pc),
        .id_imm            (id_imm),
        .pred_taken        (pred_taken),
        .id_redirect_valid (id_redirect_valid),
        .id_redirect_pc    (id_redirect_pc),
        .ex_valid          (ex_valid),
        .ex_is_branch      (ex_is_branch),
        .ex_pred_taken     (ex_pred_taken),
        .ex_stall          (ex_stall),
        .ex_pc             (ex_pc),
        .ex_imm            (ex_imm),
        .cmp_taken         (cmp_taken),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .flush_if          (flush_if),
        .flush_id          (flush_id),
        .branch_cnt        (branch_cnt),
        .mispred_cnt       (mispred_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] imm);
        id_valid = v; id_is_branch = v; id_pc = pc; id_imm = imm;
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                          input logic taken, input logic pred, input logic stall);
        ex_valid = v; ex_is_branch = v; ex_pc = pc; ex_imm = imm;
        cmp_taken = taken; ex_pred_taken = pred; ex_stall = stall;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_id(1'b0, 32'h0, 32'h0);
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        chk("rst_rv", {31'b0, redirect_valid}, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_flush", {30'b0, flush_if, flush_id}, 32'd0);
        chk("rst_bcnt", branch_cnt, 32'd0);
        chk("rst_mcnt", mispred_cnt, 32'd0);

        // Fresh BHT is weakly not-taken
        set_id(1'b1, 32'h40, 32'h20);
        chk("init_pred", {31'b0, pred_taken}, 32'd0);
        chk("init_idrv", {31'b0, id_redirect_valid}, 32'd0);
        chk("idrpc", id_redirect_pc, 32'h60);
        set_id(1'b0, 32'h40, 32'h20);
        chk("nobr_pred", {31'b0, pred_taken}, 32'd0);

        // Three correctly predicted taken resolves: 01->10->11->11
        for (int i = 0; i < 3; i++) begin
            set_ex(1'b1, 32'h40, 32'h20, 1'b1, 1'b1, 1'b0);
            tick();
        end
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        set_id(1'b1, 32'h40, 32'h20);
        chk("tk3_pred", {31'b0, pred_taken}, 32'd1);
        chk("tk3_idrv", {31'b0, id_redirect_valid}, 32'd1);
        chk("tk3_idrpc", id_redirect_pc, 32'h60);
        chk("tk3_bcnt", branch_cnt, 32'd3);
        chk("tk3_mcnt", mispred_cnt, 32'd0);
        chk("tk3_rv", {31'b0, redirect_valid}, 32'd0);

        // Saturation: 11 -> 10 still taken, -> 01 not taken
        set_ex(1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("sat1_pred", {31'b0, pred_taken}, 32'd1);
        tick();
        chk("sat2_pred", {31'b0, pred_taken}, 32'd0);

        // Same-cycle read/write to one entry: ID sees old value, then 01->10
        set_ex(1'b1, 32'h40, 32'h20, 1'b1, 1'b1, 1'b0);
        chk("byp_pred", {31'b0, pred_taken}, 32'd0);
        tick();
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("byp_post", {31'b0, pred_taken}, 32'd1);
        chk("byp_bcnt", branch_cnt, 32'd6);

        // Mispredict (taken, backward) with ID redirect in same cycle: EX wins
        set_ex(1'b1, 32'h100, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0);
        chk("prio_pred", {31'b0, pred_taken}, 32'd1);
        chk("prio_idrv", {31'b0, id_redirect_valid}, 32'd0);
        tick();
        // N+1: a mispredicting EX branch here must be ignored
        set_ex(1'b1, 32'h200, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("mp1_rv", {31'b0, redirect_valid}, 32'd1);
        chk("mp1_rpc", redirect_pc, 32'hF8);
        chk("mp1_flush", {30'b0, flush_if, flush_id}, 32'd3);
        chk("mp1_mcnt", mispred_cnt, 32'd1);
        chk("mp1_bcnt", branch_cnt, 32'd7);
        chk("mp1_idrv", {31'b0, id_redirect_valid}, 32'd0);
        tick();
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("mp2_rv", {31'b0, redirect_valid}, 32'd0);
        chk("mp2_flush", {30'b0, flush_if, flush_id}, 32'd3);
        chk("mp2_mcnt", mispred_cnt, 32'd1);
        chk("mp2_bcnt", branch_cnt, 32'd7);
        tick();
        chk("mp3_flush", {30'b0, flush_if, flush_id}, 32'd0);
        chk("mp3_idrv", {31'b0, id_redirect_valid}, 32'd1);

        // Not-taken mispredict: redirect to fall-through
        set_id(1'b0, 32'h0, 32'h0);
        set_ex(1'b1, 32'h200, 32'h40, 1'b0, 1'b1, 1'b0);
        tick();
        set_ex(1'b1, 32'h300, 32'h10, 1'b1, 1'b0, 1'b0);
        chk("nt_rv", {31'b0, redirect_valid}, 32'd1);
        chk("nt_rpc", redirect_pc, 32'h204);
        chk("nt_mcnt", mispred_cnt, 32'd2);
        chk("nt_bcnt", branch_cnt, 32'd8);
        tick();
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("ign_rv", {31'b0, redirect_valid}, 32'd0);
        chk("ign_rpc", redirect_pc, 32'h204);
        chk("ign_mcnt", mispred_cnt, 32'd2);
        chk("ign_bcnt", branch_cnt, 32'd8);
        tick();
        chk("ign_flush", {30'b0, flush_if, flush_id}, 32'd0);

        // Stalled branch at 0x44 (entry 01) resolves once when released
        for (int i = 0; i < 3; i++) begin
            set_ex(1'b1, 32'h44, 32'h0, 1'b1, 1'b1, 1'b1);
            tick();
            chk("stl_bcnt", branch_cnt, 32'd8);
        end
        set_ex(1'b1, 32'h44, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("stl_rel_bcnt", branch_cnt, 32'd9);
        set_id(1'b1, 32'h44, 32'h0);
        chk("stl_pred", {31'b0, pred_taken}, 32'd1);
        // One decrement must bring a single-updated entry (10) back to 01
        set_ex(1'b1, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("stl_once", {31'b0, pred_taken}, 32'd0);
        chk("stl_bcnt2", branch_cnt, 32'd10);

        // Reset during recovery
        set_ex(1'b1, 32'h48, 32'h8, 1'b1, 1'b0, 1'b0);
        tick();
        set_ex(1'b1, 32'h48, 32'h8, 1'b1, 1'b0, 1'b0);
        chk("rr_flush1", {30'b0, flush_if, flush_id}, 32'd3);
        chk("rr_rpc1", redirect_pc, 32'h50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rr_flush", {30'b0, flush_if, flush_id}, 32'd0);
        chk("rr_rv", {31'b0, redirect_valid}, 32'd0);
        chk("rr_rpc", redirect_pc, 32'd0);
        chk("rr_bcnt", branch_cnt, 32'd0);
        chk("rr_mcnt", mispred_cnt, 32'd0);
        set_id(1'b1, 32'h40, 32'h0);
        chk("rr_bht40", {31'b0, pred_taken}, 32'd0);
        set_id(1'b1, 32'h48, 32'h0);
        chk("rr_bht48", {31'b0, pred_taken}, 32'd0);
        // IDLE after reset: resolves count again
        set_ex(1'b1, 32'h4C, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rr_idle_bcnt", branch_cnt, 32'd1);
        chk("rr_idle_flush", {30'b0, flush_if, flush_id}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
